// File: rtl/led7_pkg.sv
// Shared definitions for the 7-segment scan driver.
//   SEG_BLANK : segment pattern with every segment off (active-low)
//   SEG_TABLE : hex digit 0..F -> segments gfedcba (bit0 = a), active-low
//   seg_of()  : table lookup helper
package led7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] seg_of(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/led7_seg_rom.sv
// Combinational hex-nibble to 7-segment decoder.
//   i_nibble  in  4  hex value
//   o_seg     out 7  segments gfedcba, active-low
module led7_seg_rom
    import led7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = seg_of(i_nibble);

endmodule

// File: rtl/led7_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// One digit is driven per refresh slot; new values are double-buffered and
// only take effect at a frame boundary so a frame is never torn.
//   i_clk       in   clock
//   i_rst_n     in   async active-low reset
//   i_en        in   global enable, 0 blanks everything
//   i_load      in   capture i_value/i_dp into the shadow buffer
//   i_value     in   4*N_DIGITS hex nibbles, digit 0 in the low nibble
//   i_dp        in   decimal point per digit, 1 = lit
//   i_digit_en  in   per-digit enable
//   i_blink     in   per-digit blink request
//   i_lzb       in   leading-zero blanking enable
//   o_7seg      out  segments gfedcba, active-low
//   o_dp        out  decimal point, active-low
//   o_anode     out  digit select, polarity set by ANODE_ACT_LOW
//   o_frame     out  one-cycle pulse at each frame start
module led7_scan_driver
    import led7_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int BLINK_FRAMES  = 64,
    parameter int ANODE_ACT_LOW = 1
)
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic [4*N_DIGITS-1:0]   i_value,
    input  logic [N_DIGITS-1:0]     i_dp,
    input  logic [N_DIGITS-1:0]     i_digit_en,
    input  logic [N_DIGITS-1:0]     i_blink,
    input  logic                    i_lzb,
    output logic [6:0]              o_7seg,
    output logic                    o_dp,
    output logic [N_DIGITS-1:0]     o_anode,
    output logic                    o_frame
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic             ANODE_ON = (ANODE_ACT_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    logic [PRE_W-1:0]        prescaler;
    logic [IDX_W-1:0]        idx;
    logic [4*N_DIGITS-1:0]   shadow_val, active_val;
    logic [N_DIGITS-1:0]     shadow_dp, active_dp;
    logic                    pending;
    logic [BLK_W-1:0]        blink_cnt;
    logic                    blink_on;

    logic                    tick, frame_start;
    logic [3:0]              cur_nibble;
    logic                    cur_dp, cur_en, cur_blink, cur_lz, upper_zero;
    logic                    blank;
    logic [6:0]              rom_seg, seg_next;
    logic                    dp_next;
    logic [N_DIGITS-1:0]     anode_next;

    assign tick        = (prescaler == PRE_LAST);
    assign frame_start = tick && (idx == IDX_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prescaler <= '0;
            idx       <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PRE_W'(1);
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // A load coinciding with frame start: active takes the old shadow and
    // the new data stays pending for the following frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            active_val <= '0;
            active_dp  <= '0;
            pending    <= 1'b0;
        end else begin
            if (frame_start && pending) begin
                active_val <= shadow_val;
                active_dp  <= shadow_dp;
            end
            if (i_load) begin
                shadow_val <= i_value;
                shadow_dp  <= i_dp;
                pending    <= 1'b1;
            end else if (frame_start) begin
                pending    <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end
    end

    // Walk digits from the top down so upper_zero holds "this digit and all
    // above it are zero" when the scanned digit is reached.
    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        cur_blink  = 1'b0;
        cur_lz     = 1'b0;
        upper_zero = 1'b1;
        for (int d = N_DIGITS - 1; d >= 0; d--) begin
            upper_zero = upper_zero && (active_val[4*d +: 4] == 4'h0);
            if (idx == IDX_W'(d)) begin
                cur_nibble = active_val[4*d +: 4];
                cur_dp     = active_dp[d];
                cur_en     = i_digit_en[d];
                cur_blink  = i_blink[d];
                cur_lz     = upper_zero && (d != 0);
            end
        end
    end

    led7_seg_rom u_seg_rom (
        .i_nibble (cur_nibble),
        .o_seg    (rom_seg)
    );

    always_comb begin
        blank    = !i_en || !cur_en || (cur_blink && !blink_on) || (i_lzb && cur_lz);
        seg_next = blank ? SEG_BLANK : rom_seg;
        dp_next  = blank ? 1'b1 : ~cur_dp;
        for (int d = 0; d < N_DIGITS; d++) begin
            anode_next[d] = (!blank && (idx == IDX_W'(d))) ? ANODE_ON : ~ANODE_ON;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_7seg  <= SEG_BLANK;
            o_dp    <= 1'b1;
            o_anode <= {N_DIGITS{~ANODE_ON}};
            o_frame <= 1'b0;
        end else begin
            o_7seg  <= seg_next;
            o_dp    <= dp_next;
            o_anode <= anode_next;
            o_frame <= frame_start;
        end
    end

endmodule

// File: tb/tb_led7_scan_driver.sv
module tb_led7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int BF    = 2;
    localparam int FRAME = N * DIV;

    localparam logic [6:0] REF_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en, load, lzb;
    logic [15:0] value;
    logic [3:0]  dp, den, blink;
    logic [6:0]  seg;
    logic        odp;
    logic [3:0]  anode;
    logic        frame;

    int checks = 0;
    int failures = 0;
    bit mon_on = 1'b0;

    always #5 clk = ~clk;

    led7_scan_driver #(
        .N_DIGITS(N), .REFRESH_DIV(DIV), .BLINK_FRAMES(BF), .ANODE_ACT_LOW(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_load(load),
        .i_value(value), .i_dp(dp), .i_digit_en(den), .i_blink(blink),
        .i_lzb(lzb), .o_7seg(seg), .o_dp(odp), .o_anode(anode), .o_frame(frame)
    );

    // Reference model: position in the scan is derived from the number of
    // clock edges since reset; buffers follow the load/frame-start rules.
    int          c;
    logic [15:0] m_shadow, m_active;
    logic [3:0]  m_shdp, m_acdp;
    bit          m_pend;
    logic [6:0]  exp_seg   = 7'h7F;
    logic        exp_dp    = 1'b1;
    logic [3:0]  exp_anode = 4'hF;
    logic        exp_frame = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int  d, f;
        bit  lit;
        logic [3:0] nib;
        if (!rst_n) begin
            c = 0; m_shadow = '0; m_active = '0; m_shdp = '0; m_acdp = '0; m_pend = 0;
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_anode = 4'hF; exp_frame = 1'b0;
        end else begin
            d   = (c / DIV) % N;
            f   = c / FRAME;
            nib = m_active[4*d +: 4];
            lit = en && den[d] && !(blink[d] && ((f / BF) % 2 == 1))
                  && !(lzb && d != 0 && (m_active >> (4*d)) == 16'h0);
            exp_seg   = lit ? REF_SEG[nib] : 7'h7F;
            exp_dp    = lit ? ~m_acdp[d] : 1'b1;
            exp_anode = lit ? ~(4'b0001 << d) : 4'hF;
            exp_frame = ((c + 1) % FRAME == 0);
            c++;
            if (c % FRAME == 0 && m_pend) begin
                m_active = m_shadow; m_acdp = m_shdp; m_pend = 0;
            end
            if (load) begin
                m_shadow = value; m_shdp = dp; m_pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if (seg !== exp_seg || odp !== exp_dp || anode !== exp_anode || frame !== exp_frame) begin
                failures++;
                $display("FAIL model t=%0t seg=%h/%h dp=%b/%b anode=%b/%b frame=%b/%b (actual/required)",
                         $time, seg, exp_seg, odp, exp_dp, anode, exp_anode, frame, exp_frame);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic [3:0]      den;
        logic            lzb;
        logic            en;
        logic [3:0][6:0] segs;   // {d3, d2, d1, d0}
    } vec_t;

    vec_t vecs [10];

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame && n < 40);
        chk("frame_seen", {31'b0, frame}, 32'd1);
    endtask

    task automatic load_val(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic sample_frame(input int k);
        for (int d = 0; d < 4; d++) begin
            logic [6:0] es;
            logic       edp;
            logic [3:0] ea;
            if (d == 0) @(negedge clk);
            else repeat (4) @(negedge clk);
            es  = vecs[k].segs[d];
            edp = (es != 7'h7F) ? ~vecs[k].dp[d] : 1'b1;
            ea  = (es != 7'h7F) ? ~(4'b0001 << d) : 4'hF;
            chk($sformatf("vec%0d_d%0d_seg", k, d), {25'b0, seg}, {25'b0, es});
            chk($sformatf("vec%0d_d%0d_dp", k, d), {31'b0, odp}, {31'b0, edp});
            chk($sformatf("vec%0d_d%0d_anode", k, d), {28'b0, anode}, {28'b0, ea});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit lit [8];
        int nlit;

        vecs[0] = '{16'h1234, 4'b0000, 4'b1111, 1'b0, 1'b1, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'hABCD, 4'b0000, 4'b1111, 1'b0, 1'b1, {7'h08, 7'h03, 7'h46, 7'h21}};
        vecs[2] = '{16'h0050, 4'b0000, 4'b1111, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}};
        vecs[3] = '{16'h0000, 4'b0000, 4'b1111, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[4] = '{16'h5678, 4'b0100, 4'b1111, 1'b0, 1'b1, {7'h12, 7'h02, 7'h78, 7'h00}};
        vecs[5] = '{16'h9EF0, 4'b0000, 4'b1010, 1'b0, 1'b1, {7'h10, 7'h7F, 7'h0E, 7'h7F}};
        vecs[6] = '{16'h1234, 4'b0000, 4'b1111, 1'b0, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        vecs[7] = '{16'h0700, 4'b0000, 4'b1111, 1'b1, 1'b1, {7'h7F, 7'h78, 7'h40, 7'h40}};
        vecs[8] = '{16'h0000, 4'b0000, 4'b1111, 1'b0, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[9] = '{16'hC0D0, 4'b1111, 4'b1111, 1'b1, 1'b1, {7'h46, 7'h40, 7'h21, 7'h40}};

        en = 1'b1; load = 1'b0; value = '0; dp = '0; den = 4'hF; blink = '0; lzb = 1'b0;
        #1 rst_n = 1'b0;
        #1 mon_on = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_seg", {25'b0, seg}, 32'h7F);
        chk("reset_dp", {31'b0, odp}, 32'd1);
        chk("reset_anode", {28'b0, anode}, 32'hF);
        chk("reset_frame", {31'b0, frame}, 32'd0);
        rst_n = 1'b1;

        // Basic scan of 1234 and frame period
        load_val(16'h1234);
        wait_frame();
        sample_frame(0);
        wait_frame();
        n = 0;
        do begin @(negedge clk); n++; end while (!frame && n < 40);
        chk("frame_period", n, FRAME);
        @(negedge clk);
        chk("frame_one_cycle", {31'b0, frame}, 32'd0);

        // Table-driven vectors
        for (int k = 0; k < 10; k++) begin
            dp = vecs[k].dp; den = vecs[k].den; lzb = vecs[k].lzb; en = vecs[k].en;
            load_val(vecs[k].value);
            wait_frame();
            wait_frame();
            sample_frame(k);
        end

        // Double buffer: mid-frame load must not disturb the current frame
        dp = '0; den = 4'hF; lzb = 1'b0; en = 1'b1;
        load_val(16'h1234);
        wait_frame();
        wait_frame();
        wait_frame();
        repeat (7) @(negedge clk);
        load_val(16'hABCD);
        @(negedge clk);
        chk("dbuf_d2_seg", {25'b0, seg}, 32'h24);
        chk("dbuf_d2_anode", {28'b0, anode}, 32'hB);
        repeat (4) @(negedge clk);
        chk("dbuf_d3_seg", {25'b0, seg}, 32'h79);
        chk("dbuf_d3_anode", {28'b0, anode}, 32'h7);
        wait_frame();
        sample_frame(1);

        // Load coincident with frame start
        wait_frame();
        repeat (3) @(negedge clk);
        load_val(16'h1111);
        repeat (11) @(negedge clk);
        value = 16'h2222;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        chk("coinc_frame_edge", {31'b0, frame}, 32'd1);
        @(negedge clk);
        chk("coinc_old_shadow", {25'b0, seg}, 32'h79);
        wait_frame();
        @(negedge clk);
        chk("coinc_new_pending", {25'b0, seg}, 32'h24);

        // Blink on digit 0: two frames lit, two frames blank
        load_val(16'h1234);
        wait_frame();
        wait_frame();
        blink = 4'b0001;
        nlit = 0;
        for (int f = 0; f < 8; f++) begin
            wait_frame();
            @(negedge clk);
            lit[f] = (anode == 4'b1110);
            if (lit[f]) nlit++;
        end
        chk("blink_lit_count", nlit, 4);
        for (int f = 0; f < 6; f++) begin
            chk($sformatf("blink_phase_f%0d", f), {31'b0, lit[f]}, {31'b0, ~lit[f+2]});
        end
        blink = 4'b0000;

        // Asynchronous reset in the middle of a slot
        wait_frame();
        repeat (6) @(negedge clk);
        chk("pre_reset_seg", {25'b0, seg}, 32'h30);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_seg", {25'b0, seg}, 32'h7F);
        chk("midreset_dp", {31'b0, odp}, 32'd1);
        chk("midreset_anode", {28'b0, anode}, 32'hF);
        chk("midreset_frame", {31'b0, frame}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Global disable: everything blank, frame pulses continue
        load_val(16'h1234);
        wait_frame();
        en = 1'b0;
        wait_frame();
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 3) chk("en0_anode", {28'b0, anode}, 32'hF);
        end while (!frame && n < 40);
        chk("en0_frame_period", n, FRAME);
        en = 1'b1;

        // Random stimulus against the model
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            value = 16'($urandom) & {{4{($urandom_range(0, 2) != 0)}}, {4{($urandom_range(0, 2) != 0)}},
                                     {4{($urandom_range(0, 2) != 0)}}, {4{1'b1}}};
            load  = ($urandom_range(0, 9) == 0);
            dp    = 4'($urandom);
            den   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            blink = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            lzb   = 1'($urandom);
            en    = ($urandom_range(0, 9) != 0);
        end
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
